// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the instruction-fetch slice.
//   - default address/data widths and reset PC for the fetch unit
//   - NOP encoding driven on instr_out while nothing valid is presented
//   - fetch FSM state enum and its next-state helper
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [8:0]  RESET_PC_DEF = 9'h000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // BOOT is a single idle cycle; RUN/HALT follow the halt_req level.
  function automatic fetch_state_e fsm_next(input fetch_state_e cur, input logic halt);
    fetch_state_e nxt;
    case (cur)
      ST_BOOT: nxt = ST_RUN;
      ST_RUN:  nxt = halt ? ST_HALT : ST_RUN;
      ST_HALT: nxt = halt ? ST_HALT : ST_RUN;
      default: nxt = ST_BOOT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: two-entry queue of {pc, instr} words feeding the IF register.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail
//   pop          drop the head
//   flush        empty the queue; beats push and pop in the same cycle
//   push_data    W-bit entry to enqueue
//   head_data    current head entry (meaningful only when count != 0)
//   count        number of valid entries, 0..2
// Entry 0 is always the head, so the output needs no read-pointer mux.
module fetch_fifo2 import cpu_pkg::*; #(
  parameter int unsigned W = 41
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok_s;
  logic         push_ok_s;

  // Ignore pop on an empty queue and push on a full one that is not popping.
  assign pop_ok_s  = pop & (cnt_q != 2'd0);
  assign push_ok_s = push & ((cnt_q != 2'd2) | pop_ok_s);

  // Next-state for the shift-style queue: entry 1 moves into entry 0 on pop.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      ent0_d = {W{1'b0}};
      ent1_d = {W{1'b0}};
      cnt_d  = 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            ent0_d = push_data;
          end else begin
            ent1_d = push_data;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_d = push_data;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Queue storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= {W{1'b0}};
      ent1_q <= {W{1'b0}};
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data = ent0_q;
  assign count     = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end.
// Holds the PC, issues word reads to a synchronous imem (1-cycle latency),
// buffers returned words in a 2-entry queue and presents {pc, instr} with
// valid/ready to the IF pipeline register.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   imem_addr      imem word address (= pc_q)
//   imem_rd_en     imem read strobe; data comes back on imem_rdata next cycle
//   imem_rdata     imem read data
//   redirect_vld   taken branch/jump: restart fetch at redirect_pc, squash queue
//   redirect_pc    redirect target (word address)
//   halt_req       level; no new fetches once the FSM has entered HALT
//   instr_vld      instr_out/pc_out valid
//   instr_ready    IF register accepts; transfer = instr_vld & instr_ready
//   instr_out      fetched instruction, NOP when !instr_vld
//   pc_out         word address of instr_out, 0 when !instr_vld
module if_fetch_unit import cpu_pkg::*; #(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_vld,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              instr_vld,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;

  logic [1:0]        fifo_count_s;
  logic [ENT_W-1:0]  fifo_head_s;
  logic [ENT_W-1:0]  fifo_push_data_s;
  logic              head_vld_s;
  logic              pop_raw_s;
  logic              fifo_pop_s;
  logic [2:0]        occ_s;
  logic              can_issue_s;

  assign head_vld_s = (fifo_count_s != 2'd0);
  assign pop_raw_s  = head_vld_s & instr_ready;

  // A redirect squashes the shown head, so it must not count as consumed.
  assign fifo_pop_s = pop_raw_s & ~redirect_vld;

  // Slots that will be occupied after this edge; issuing is allowed while a
  // slot is still free for the word that would come back.
  assign occ_s = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_raw_s};

  assign can_issue_s = (state_q == ST_RUN) & ~redirect_vld & (occ_s < 3'd2);

  // PC, in-flight tracking and FSM next-state; redirect overrides issue.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    state_d       = fsm_next(state_q, halt_req);
    if (redirect_vld) begin
      pc_d       = redirect_pc;
      inflight_d = 1'b0;
    end else if (can_issue_s) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end else begin
      inflight_d = 1'b0;
    end
  end

  // FSM state, PC and in-flight registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= {ADDR_W{1'b0}};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign fifo_push_data_s = {inflight_pc_q, imem_rdata};

  fetch_fifo2 #(
    .W (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .pop       (fifo_pop_s),
    .flush     (redirect_vld),
    .push_data (fifo_push_data_s),
    .head_data (fifo_head_s),
    .count     (fifo_count_s)
  );

  assign imem_addr  = pc_q;
  assign imem_rd_en = can_issue_s;
  assign instr_vld  = head_vld_s;
  assign instr_out  = head_vld_s ? fifo_head_s[DATA_W-1:0] : DATA_W'(NOP_INSTR);
  assign pc_out     = head_vld_s ? fifo_head_s[ENT_W-1:DATA_W] : {ADDR_W{1'b0}};

endmodule
